core_memory_responder: RTL and testbench

Single-clock, dual-port word memory that services the pipelined core's instruction-fetch and data-memory ports.
- Returns registered read data one cycle after each request.
- Applies byte-masked writes.
- Flags out-of-range accesses.
- Provides a valid/ready loader port. The loader port holds the core, drains in-flight traffic, then streams whole-word writes, for program download.

---
 rtl/core_memory_responder.sv | 152 +++++++++++++++
 tb/tb_core_memory_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_memory_responder.sv
// Dual-port word memory serving the core's fetch and data ports, with a
// valid/ready loader that freezes the core and streams whole words into the array.
module core_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LOAD_DRAIN  = 2
) (
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        clk_en,
  input  logic [29:0] inst_address,
  input  logic        inst_req,
  output logic [31:0] inst_in,
  input  logic        bus_lock,
  input  logic        memory_mode,
  input  logic [29:0] data_address,
  input  logic [3:0]  data_mask,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [29:0] ld_address,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        core_hold,
  output logic        access_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LOAD_DRAIN + 2);

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, RELEASE} state_e;

  logic [31:0] mem [DEPTH_WORDS];

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   inst_in_q, inst_in_d;
  logic [31:0]   data_in_q, data_in_d;
  logic          fault_q, fault_d;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;

  logic inst_ok, data_ok, ld_ok, drain_done;

  assign inst_ok    = (inst_address >> AW) == 30'd0;
  assign data_ok    = (data_address >> AW) == 30'd0;
  assign ld_ok      = (ld_address >> AW) == 30'd0;
  assign drain_done = (32'(cnt_q) + 32'd1) >= LOAD_DRAIN;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    inst_in_d = inst_in_q;
    data_in_d = data_in_q;
    fault_d   = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_data   = '0;
    wr_be     = '0;

    // Reads sample the array before this edge's write lands (read-before-write).
    if (inst_req) begin
      if (inst_ok) begin
        inst_in_d = mem[inst_address[AW-1:0]];
      end else begin
        inst_in_d = '0;
        fault_d   = 1'b1;
      end
    end

    if (state_q == LOAD) begin
      if (ld_valid) begin
        if (ld_ok) begin
          wr_en   = 1'b1;
          wr_idx  = ld_address[AW-1:0];
          wr_data = ld_data;
          wr_be   = 4'hF;
        end else begin
          fault_d = 1'b1;
        end
      end
    end else if (data_mask != 4'h0) begin
      if (!data_ok) begin
        fault_d = 1'b1;
        if (!memory_mode) data_in_d = '0;
      end else if (memory_mode) begin
        wr_en   = 1'b1;
        wr_idx  = data_address[AW-1:0];
        wr_data = data_out;
        wr_be   = data_mask;
      end else begin
        data_in_d = mem[data_address[AW-1:0]];
      end
    end

    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          if (!bus_lock) state_d = LOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LOAD: begin
        if (ld_valid && ld_last) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      inst_in_q <= '0;
      data_in_q <= '0;
      fault_q   <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      inst_in_q <= inst_in_d;
      data_in_q <= data_in_d;
      fault_q   <= fault_d;
    end
  end

  // Array contents are deliberately left out of reset so a load survives it.
  always_ff @(posedge clk) begin
    if (clk_en && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign inst_in      = inst_in_q;
  assign data_in      = data_in_q;
  assign access_fault = fault_q;
  assign ld_ready     = (state_q == LOAD);
  assign core_hold    = (state_q != IDLE);

endmodule

// File: tb/tb_core_memory_responder.sv
// Self-checking bench for core_memory_responder: directed vector table, randomized
// traffic against a word-array model, and hand-written loader/clk_en/reset sequences.
module tb_core_memory_responder;

  localparam int DEPTH = 4096;
  localparam int DRAIN = 2;

  logic        clk, async_rst_n, clk_en;
  logic [29:0] inst_address;
  logic        inst_req;
  logic [31:0] inst_in;
  logic        bus_lock, memory_mode;
  logic [29:0] data_address;
  logic [3:0]  data_mask;
  logic [31:0] data_out, data_in;
  logic        ld_valid, ld_ready;
  logic [29:0] ld_address;
  logic [31:0] ld_data;
  logic        ld_last, core_hold, access_fault;

  int pass_count  = 0;
  int total_count = 0;

  core_memory_responder #(.DEPTH_WORDS(DEPTH), .LOAD_DRAIN(DRAIN)) dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
    .inst_address(inst_address), .inst_req(inst_req), .inst_in(inst_in),
    .bus_lock(bus_lock), .memory_mode(memory_mode), .data_address(data_address),
    .data_mask(data_mask), .data_out(data_out), .data_in(data_in),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_address(ld_address),
    .ld_data(ld_data), .ld_last(ld_last), .core_hold(core_hold),
    .access_fault(access_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        inst_req;
    logic [29:0] inst_addr;
    logic [3:0]  mask;
    logic        mode;
    logic [29:0] daddr;
    logic [31:0] wdata;
    logic [31:0] exp_inst;
    logic [31:0] exp_data;
    logic        exp_fault;
  } vec_t;

  vec_t vecs [15];

  // Reference model: a plain word array for the addresses the random phase uses.
  logic [31:0] model_mem [64];
  logic [31:0] model_inst, model_data;
  logic        model_fault;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic apply_stimulus(input vec_t v);
    inst_req     = v.inst_req;
    inst_address = v.inst_addr;
    data_mask    = v.mask;
    memory_mode  = v.mode;
    data_address = v.daddr;
    data_out     = v.wdata;
    step();
  endtask

  function automatic logic [29:0] gen_addr();
    logic [29:0] r;
    r = 30'($urandom_range(0, 63));
    if ($urandom_range(0, 9) == 0) r = r + 30'h1000;
    return r;
  endfunction

  task automatic random_cycle(input logic ce, input logic req, input logic [29:0] ia,
                              input logic [3:0] mask, input logic mode,
                              input logic [29:0] da, input logic [31:0] wd);
    clk_en = ce; inst_req = req; inst_address = ia;
    data_mask = mask; memory_mode = mode; data_address = da; data_out = wd;
    if (ce) begin
      model_fault = 1'b0;
      if (req) begin
        if (ia < DEPTH) model_inst = model_mem[ia[5:0]];
        else begin model_inst = 32'h0; model_fault = 1'b1; end
      end
      if (mask != 4'h0) begin
        if (da >= DEPTH) begin
          model_fault = 1'b1;
          if (!mode) model_data = 32'h0;
        end else if (mode) begin
          for (int b = 0; b < 4; b++)
            if (mask[b]) model_mem[da[5:0]][8*b +: 8] = wd[8*b +: 8];
        end else begin
          model_data = model_mem[da[5:0]];
        end
      end
    end
    step();
    check_output("rand_inst", inst_in, model_inst);
    check_output("rand_data", data_in, model_data);
    check_output("rand_fault", {31'h0, access_fault}, {31'h0, model_fault});
  endtask

  task automatic read_word(input string name, input logic [29:0] a, input logic [31:0] exp);
    data_mask = 4'hF; memory_mode = 1'b0; data_address = a;
    step();
    data_mask = 4'h0;
    check_output(name, data_in, exp);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    async_rst_n = 1'b0; clk_en = 1'b1; inst_req = 1'b0; inst_address = '0;
    bus_lock = 1'b0; memory_mode = 1'b0; data_address = '0; data_mask = '0;
    data_out = '0; ld_valid = 1'b0; ld_address = '0; ld_data = '0; ld_last = 1'b0;

    vecs[0]  = '{1'b0, 30'd0,  4'hF, 1'b1, 30'd0, 32'h01020304, 32'h0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 30'd0,  4'hF, 1'b1, 30'd4, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 30'd0,  4'hF, 1'b1, 30'd8, 32'h11223344, 32'h0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 30'd0,  4'hF, 1'b1, 30'd3, 32'h00000009, 32'h0, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 30'd4,  4'h0, 1'b0, 30'd0, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 30'd0,  4'b0101, 1'b1, 30'd8, 32'hAABBCCDD, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 30'd0,  4'hF, 1'b0, 30'd8, 32'h0, 32'hDEADBEEF, 32'h11BB33DD, 1'b0};
    vecs[7]  = '{1'b1, 30'd3,  4'hF, 1'b1, 30'd3, 32'h00000005, 32'h9, 32'h11BB33DD, 1'b0};
    vecs[8]  = '{1'b1, 30'd3,  4'h0, 1'b0, 30'd0, 32'h0, 32'h5, 32'h11BB33DD, 1'b0};
    vecs[9]  = '{1'b0, 30'd0,  4'b0001, 1'b0, 30'h1000, 32'h0, 32'h5, 32'h0, 1'b1};
    vecs[10] = '{1'b0, 30'd0,  4'h0, 1'b0, 30'd0, 32'h0, 32'h5, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 30'd0,  4'hF, 1'b1, 30'h1000, 32'hFFFFFFFF, 32'h5, 32'h0, 1'b1};
    vecs[12] = '{1'b0, 30'd0,  4'hF, 1'b0, 30'd0, 32'h0, 32'h5, 32'h01020304, 1'b0};
    vecs[13] = '{1'b1, 30'h20000000, 4'h0, 1'b0, 30'd0, 32'h0, 32'h0, 32'h01020304, 1'b1};
    vecs[14] = '{1'b1, 30'd8,  4'b0010, 1'b0, 30'd4, 32'h0, 32'h11BB33DD, 32'hDEADBEEF, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_inst", inst_in, 32'h0);
    check_output("rst_data", data_in, 32'h0);
    check_output("rst_ready", {31'h0, ld_ready}, 32'h0);
    check_output("rst_hold", {31'h0, core_hold}, 32'h0);
    check_output("rst_fault", {31'h0, access_fault}, 32'h0);
    async_rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d_inst", i), inst_in, vecs[i].exp_inst);
      check_output($sformatf("vec%0d_data", i), data_in, vecs[i].exp_data);
      check_output($sformatf("vec%0d_fault", i), {31'h0, access_fault}, {31'h0, vecs[i].exp_fault});
    end

    model_inst = 32'h11BB33DD; model_data = 32'hDEADBEEF; model_fault = 1'b0;
    for (int i = 0; i < 64; i++)
      random_cycle(1'b1, 1'b0, 30'd0, 4'hF, 1'b1, 30'(i), $urandom());
    for (int i = 0; i < 300; i++)
      random_cycle(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), gen_addr(),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), gen_addr(), $urandom());
    clk_en = 1'b1; inst_req = 1'b0; data_mask = 4'h0;

    // Loader with bus_lock held past the drain window.
    bus_lock = 1'b1;
    ld_valid = 1'b1; ld_address = 30'd0; ld_data = 32'hA0A0A0A0; ld_last = 1'b0;
    step();
    check_output("ldA_hold_rise", {31'h0, core_hold}, 32'h1);
    check_output("ldA_ready_idle", {31'h0, ld_ready}, 32'h0);
    ld_valid = 1'b0;
    for (int i = 0; i < DRAIN + 2; i++) begin
      step();
      check_output($sformatf("ldA_drain%0d_ready", i), {31'h0, ld_ready}, 32'h0);
      check_output($sformatf("ldA_drain%0d_hold", i), {31'h0, core_hold}, 32'h1);
    end
    bus_lock = 1'b0; ld_valid = 1'b1;
    step();
    check_output("ldA_grant", {31'h0, ld_ready}, 32'h1);
    data_mask = 4'hF; memory_mode = 1'b1; data_address = 30'd5; data_out = 32'hBADBAD00;
    step();
    data_mask = 4'h0; ld_valid = 1'b0;
    step();
    check_output("ldA_stall_ready", {31'h0, ld_ready}, 32'h1);
    ld_valid = 1'b1; ld_address = 30'd1; ld_data = 32'hA1A1A1A1;
    step();
    ld_address = 30'd2; ld_data = 32'hA2A2A2A2; ld_last = 1'b1;
    step();
    check_output("ldA_release_ready", {31'h0, ld_ready}, 32'h0);
    check_output("ldA_release_hold", {31'h0, core_hold}, 32'h1);
    ld_valid = 1'b0; ld_last = 1'b0;
    step();
    check_output("ldA_hold_fall", {31'h0, core_hold}, 32'h0);
    read_word("ldA_word0", 30'd0, 32'hA0A0A0A0);
    read_word("ldA_word1", 30'd1, 32'hA1A1A1A1);
    read_word("ldA_word2", 30'd2, 32'hA2A2A2A2);
    read_word("ldA_core_write_dropped", 30'd5, model_mem[5]);

    // Second load: clk_en freeze mid-LOAD, loader fault, then reset mid-LOAD.
    ld_valid = 1'b1; ld_address = 30'd10; ld_data = 32'hB0B0B0B0;
    waited = 0;
    while (!ld_ready && waited < 20) begin
      step();
      waited++;
    end
    check_output("ldB_grant", {31'h0, ld_ready}, 32'h1);
    clk_en = 1'b0; ld_address = 30'd11; ld_data = 32'hB1B1B1B1; ld_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_output($sformatf("ldB_frozen%0d_ready", i), {31'h0, ld_ready}, 32'h1);
      check_output($sformatf("ldB_frozen%0d_hold", i), {31'h0, core_hold}, 32'h1);
    end
    ld_last = 1'b0; clk_en = 1'b1;
    step();
    check_output("ldB_resume_ready", {31'h0, ld_ready}, 32'h1);
    ld_address = 30'd12; ld_data = 32'hB2B2B2B2;
    step();
    ld_address = 30'h1000; ld_data = 32'hFFFFFFFF;
    step();
    check_output("ldB_oor_fault", {31'h0, access_fault}, 32'h1);
    ld_valid = 1'b0;
    step();
    check_output("ldB_fault_pulse_end", {31'h0, access_fault}, 32'h0);
    #2 async_rst_n = 1'b0;
    #1;
    check_output("ldB_rst_hold", {31'h0, core_hold}, 32'h0);
    check_output("ldB_rst_ready", {31'h0, ld_ready}, 32'h0);
    check_output("ldB_rst_data", data_in, 32'h0);
    #4 async_rst_n = 1'b1;
    step();
    read_word("ldB_word11", 30'd11, 32'hB1B1B1B1);
    read_word("ldB_word12", 30'd12, 32'hB2B2B2B2);
    read_word("ldB_oor_dropped", 30'd0, 32'hA0A0A0A0);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
